// File: rtl/trace_player.sv
// Replays a stored table of primary-input vectors onto a DUT, one vector per clock,
// with one-shot or looping playback, abort, a saturating step counter and a done pulse.
module trace_player #(
   parameter int               WIDTH     = 3,
   parameter int               DEPTH     = 16,
   parameter int               AW        = $clog2(DEPTH),
   parameter logic [WIDTH-1:0] INIT_VAL  = '0,
   parameter bit               HOLD_LAST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW:0]      len,
   input  logic             loop,
   input  logic             start,
   input  logic             abort,
   output logic [WIDTH-1:0] pi,
   output logic             pi_valid,
   output logic             busy,
   output logic             done,
   output logic [31:0]      cycle,
   output logic             wr_err
);

   typedef enum logic {S_IDLE, S_PLAY} state_t;

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   state_t           r_state;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_idx;
   logic [AW:0]      r_len;
   logic             r_loop;
   logic [WIDTH-1:0] r_pi;
   logic             r_pi_valid;
   logic             r_busy;
   logic             r_done;
   logic [31:0]      r_cycle;
   logic             r_wr_err;

   logic [AW:0]      w_len_eff;
   logic [WIDTH-1:0] w_rd_data;
   logic [WIDTH-1:0] w_mem0;
   logic [31:0]      w_cycle_inc;

   assign w_len_eff   = (len > DEPTH_L) ? DEPTH_L : len;
   assign w_rd_data   = r_mem[r_idx[AW-1:0]];
   assign w_mem0      = r_mem[0];
   assign w_cycle_inc = (r_cycle == '1) ? r_cycle : r_cycle + 32'd1;

   // Table has no reset so a trace survives rst; writes only land while idle.
   always_ff @(posedge clk) begin
      if (wr_en && (r_state == S_IDLE))
         r_mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_len      <= '0;
         r_loop     <= 1'b0;
         r_pi       <= INIT_VAL;
         r_pi_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cycle    <= '0;
         r_wr_err   <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_wr_err <= wr_en && (r_state == S_PLAY);
         if (abort) begin
            r_state    <= S_IDLE;
            r_pi       <= INIT_VAL;
            r_pi_valid <= 1'b0;
            r_busy     <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (start) begin
                     if (w_len_eff != '0) begin
                        r_state    <= S_PLAY;
                        r_len      <= w_len_eff;
                        r_loop     <= loop;
                        r_idx      <= (AW+1)'(1);
                        r_pi       <= w_mem0;
                        r_pi_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_cycle    <= 32'd1;
                     end else begin
                        r_done <= 1'b1;
                     end
                  end
               end
               S_PLAY: begin
                  if (r_idx < r_len) begin
                     r_pi    <= w_rd_data;
                     r_idx   <= r_idx + (AW+1)'(1);
                     r_cycle <= w_cycle_inc;
                  end else if (r_loop) begin
                     r_pi    <= w_mem0;
                     r_idx   <= (AW+1)'(1);
                     r_cycle <= w_cycle_inc;
                  end else begin
                     r_state    <= S_IDLE;
                     r_pi_valid <= 1'b0;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     if (!HOLD_LAST)
                        r_pi <= INIT_VAL;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign pi       = r_pi;
   assign pi_valid = r_pi_valid;
   assign busy     = r_busy;
   assign done     = r_done;
   assign cycle    = r_cycle;
   assign wr_err   = r_wr_err;

endmodule
